rr_port_scheduler: RTL and testbench

RR_PORT_SCHEDULER -- requirements
Module: rr_port_scheduler

---
 rtl/rr_port_scheduler_pkg.sv | 25 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_port_scheduler.sv | 127 ++++++++++++
 tb/tb_rr_port_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_port_scheduler_pkg.sv
// Shared flit type, FSM encoding and default sizing for the round-robin port scheduler.
// Latency: none (types, constants and a helper function only).
// Backpressure: none.
package rr_port_scheduler_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CREDITS = 4;

    // One flit as carried on a port: payload plus end-of-packet marker.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 tail;
    } flit_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_t;

    // Next requester index after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or above ptr, wrapping around.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // Walk the requesters starting at ptr and keep the first one that is asking.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_port_scheduler.sv
// Packet-granular round-robin scheduler of NUM_REQ requesters onto one credited output port.
// Latency: an accepted flit is presented on out_* the following cycle; one flit per cycle sustained.
// Backpressure: req_ready drops when credits run out or the output register is full and not draining.
module rr_port_scheduler
    import rr_port_scheduler_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int CREDITS = DEF_CREDITS,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_tail,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_tail,
    input  logic                     out_ready,
    input  logic                     credit_return,
    output logic                     credit_err,
    output logic [IW-1:0]            grant_id
);

    localparam int             CW       = $clog2(CREDITS + 1);
    localparam logic [CW-1:0]  CRED_MAX = CW'(CREDITS);

    sched_state_t       state;
    logic [IW-1:0]      rr_ptr;
    logic [CW-1:0]      credit_cnt;
    logic               can_accept;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [IW-1:0]      sel;
    logic               xfer;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_tail;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A slot must exist downstream and the output register must be free or emptying this cycle.
    assign can_accept = (credit_cnt != '0) && (!out_valid || out_ready);

    // Idle: offer the round-robin winner. Locked: only the packet owner may move a flit.
    always_comb begin
        req_ready = '0;
        sel       = (state == ST_LOCKED) ? grant_id : pick_idx;
        if (rst_n && can_accept) begin
            if (state == ST_IDLE) begin
                req_ready = pick_gnt;
            end else begin
                req_ready[grant_id] = req_valid[grant_id];
            end
        end
    end

    assign xfer     = |(req_valid & req_ready);
    assign sel_data = req_data[int'(sel)*WIDTH +: WIDTH];
    assign sel_tail = req_tail[sel];

    // Output register: load on accept, otherwise empty once downstream takes the flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tail  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_tail  <= sel_tail;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Ownership FSM: lock on a non-tail head flit, release and advance the pointer on a tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else if (xfer) begin
            if (state == ST_IDLE) begin
                grant_id <= pick_idx;
            end
            if (sel_tail) begin
                state  <= ST_IDLE;
                rr_ptr <= IW'(wrap_inc(32'(sel), NUM_REQ));
            end else begin
                state <= ST_LOCKED;
            end
        end
    end

    // Credit counter: spend on accept, refill on return, and flag a return with no slot owed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            case ({xfer, credit_return})
                2'b10: credit_cnt <= credit_cnt - CW'(1);
                2'b01: begin
                    if (credit_cnt == CRED_MAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_cnt <= credit_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_port_scheduler.sv
module tb_rr_port_scheduler;
    import rr_port_scheduler_pkg::*;

    localparam int N = 3;
    localparam int W = 8;
    localparam int C = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_tail;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_tail;
    logic           out_ready;
    logic           credit_return;
    logic           credit_err;
    logic [1:0]     grant_id;

    rr_port_scheduler #(.NUM_REQ(N), .WIDTH(W), .CREDITS(C)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_tail      (req_tail),
        .req_ready     (req_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_tail      (out_tail),
        .out_ready     (out_ready),
        .credit_return (credit_return),
        .credit_err    (credit_err),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    flit_t  rq [N][$];      // flits each requester still has to send
    flit_t  exp_q [$];      // scoreboard: flits expected on the output, in order
    int     mdl_ptr = 0;    // reference model round-robin start point
    int     ds_occ = 0;     // downstream slots holding flits whose credit is not yet returned
    bit     auto_cr = 1'b1;
    bit     auto_rdy = 1'b0;
    int     rdy_pct = 100;
    int     cyc = 0;
    int     nout = 0;
    int     first_cyc = 0;
    int     last_cyc = 0;
    logic   hold_prev = 1'b0;
    logic [W-1:0] hold_data = '0;
    logic   hold_tail = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops the scoreboard on every output transfer and checks held flits stay put.
    always @(negedge clk) begin : monitor
        flit_t e;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (!out_valid || out_data !== hold_data || out_tail !== hold_tail) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b d=%0h t=%0b expected v=1 d=%0h t=%0b",
                             out_valid, out_data, out_tail, hold_data, hold_tail);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_flit: got d=%0h t=%0b expected no flit", out_data, out_tail);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_tail !== e.tail) begin
                        errors++;
                        $display("FAIL out_flit: got d=%0h t=%0b expected d=%0h t=%0b",
                                 out_data, out_tail, e.data, e.tail);
                    end
                end
                if (nout == 0) first_cyc = cyc;
                last_cyc = cyc;
                nout++;
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            hold_tail = out_tail;
        end
    end

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = rq[i][0].data;
                req_tail[i]        = rq[i][0].tail;
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = '0;
                req_tail[i]        = 1'b0;
            end
        end
    endtask

    // One clock: note handshakes mid-cycle, then retire accepted flits and redrive after the edge.
    task automatic tick();
        logic [N-1:0] acc;
        logic         otx;
        @(negedge clk);
        acc = req_valid & req_ready;
        otx = out_valid & out_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        if (auto_cr) begin
            if (otx && rst_n) ds_occ++;
            if (credit_return) ds_occ--;
            credit_return = (ds_occ > 0) && ($urandom_range(99) < 60);
        end else begin
            credit_return = 1'b0;
        end
        if (auto_rdy) out_ready = ($urandom_range(99) < rdy_pct);
        drive_reqs();
    endtask

    task automatic push_flit(input int i, input logic [W-1:0] d, input logic t);
        flit_t f;
        f.data = d;
        f.tail = t;
        rq[i].push_back(f);
    endtask

    task automatic load_pkt(input int i, input int len);
        for (int f = 0; f < len; f++) push_flit(i, W'($urandom_range(255)), (f == len - 1));
    endtask

    // Reference model: whole packets leave in round-robin order over requesters with data.
    task automatic predict();
        flit_t m [N][$];
        flit_t f;
        int    p;
        int    found;
        for (int k = 0; k < N; k++) m[k] = rq[k];
        p = mdl_ptr;
        while (1) begin
            found = -1;
            for (int k = 0; k < N; k++) begin
                if (found < 0 && m[(p + k) % N].size() > 0) found = (p + k) % N;
            end
            if (found < 0) break;
            do begin
                f = m[found].pop_front();
                exp_q.push_back(f);
            end while (!f.tail && m[found].size() > 0);
            p = (found + 1) % N;
        end
        mdl_ptr = p;
    endtask

    function automatic bit busy();
        bit b;
        b = (exp_q.size() > 0) || out_valid || (auto_cr && ds_occ > 0);
        for (int k = 0; k < N; k++) if (rq[k].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input int maxc, input string name);
        int n;
        n = 0;
        while (busy() && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        if (busy()) begin
            errors++;
            $display("FAIL %s_drain: got %0d flits outstanding after %0d cycles expected 0",
                     name, exp_q.size(), maxc);
            for (int k = 0; k < N; k++) rq[k].delete();
            exp_q.delete();
            ds_occ = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) rq[k].delete();
        exp_q.delete();
        ds_occ        = 0;
        mdl_ptr       = 0;
        credit_return = 1'b0;
        drive_reqs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stim
        rst_n         = 1'b0;
        req_valid     = '1;
        req_tail      = '1;
        req_data      = '1;
        out_ready     = 1'b0;
        credit_return = 1'b0;
        #12;
        chk("rst_req_ready",  32'(req_ready), 32'h0);
        chk("rst_out_valid",  32'(out_valid), 32'h0);
        chk("rst_out_data",   32'(out_data), 32'h0);
        chk("rst_out_tail",   32'(out_tail), 32'h0);
        chk("rst_credit_err", 32'(credit_err), 32'h0);
        chk("rst_grant_id",   32'(grant_id), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_reqs();

        // Continuous single-flit packets from all three requesters.
        auto_cr = 1'b1; auto_rdy = 1'b0; out_ready = 1'b1;
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) load_pkt(i, 1);
        predict(); drive_reqs(); drain(200, "single_flit_rr");

        // Move the pointer to 1, then a 3-flit packet from 1 competes with a flit from 0.
        load_pkt(0, 1); predict(); drive_reqs(); drain(50, "ptr_prep");
        nout = 0;
        load_pkt(1, 3); load_pkt(0, 1);
        predict(); drive_reqs(); drain(100, "multi_flit");
        chk("multi_flit_count", 32'(nout), 32'd4);
        chk("multi_flit_back_to_back", 32'(last_cyc - first_cyc), 32'd3);
        // Pointer lands on 2 after the tail of 1, so 2 precedes 0 here.
        load_pkt(1, 3); load_pkt(0, 1); load_pkt(2, 1);
        predict(); drive_reqs(); drain(100, "ptr_after_tail");

        // Random packet mixes under random output backpressure.
        auto_rdy = 1'b1;
        for (int ph = 0; ph < 6; ph++) begin
            rdy_pct = $urandom_range(100, 30);
            for (int i = 0; i < N; i++) begin
                int np;
                np = $urandom_range(3, 0);
                for (int p = 0; p < np; p++) load_pkt(i, $urandom_range(4, 1));
            end
            predict(); drive_reqs(); drain(2000, "random");
        end

        // Accept-to-output latency of one cycle.
        auto_rdy = 1'b0; out_ready = 1'b1;
        push_flit(2, 8'h3C, 1'b1); predict(); drive_reqs();
        #2;
        chk("lat_req_ready", 32'(req_ready), 32'b100);
        tick();
        #2;
        chk("lat_out_valid", 32'(out_valid), 32'h1);
        chk("lat_out_data",  32'(out_data), 32'h3C);
        chk("lat_out_tail",  32'(out_tail), 32'h1);
        chk("lat_grant_id",  32'(grant_id), 32'd2);
        drain(50, "latency");

        // Output stall: flit 0xA5 held for three cycles while requester 1 waits.
        out_ready = 1'b0;
        push_flit(0, 8'hA5, 1'b1); predict(); drive_reqs();
        tick();
        push_flit(1, 8'h11, 1'b1); predict(); drive_reqs();
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("stall_out_data",  32'(out_data), 32'hA5);
            chk("stall_req_ready", 32'(req_ready), 32'h0);
            tick();
        end
        out_ready = 1'b1;
        #2;
        chk("stall_release_ready", 32'(req_ready), 32'b010);
        tick();
        #2;
        chk("stall_next_data", 32'(out_data), 32'h11);
        drain(50, "stall");

        // Credit exhaustion with no returns, then single returns release one flit each.
        do_reset();
        auto_cr = 1'b0; auto_rdy = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) push_flit(0, W'(8'h50 + k), 1'b1);
        predict(); drive_reqs();
        repeat (8) tick();
        chk("cred_exhaust_accepted", 32'(6 - rq[0].size()), 32'd4);
        #2;
        chk("cred_exhaust_ready", 32'(req_ready), 32'h0);
        credit_return = 1'b1;
        tick();
        #2;
        chk("cred_return_ready", 32'(req_ready), 32'b001);
        tick();
        chk("cred_fifth_accepted", 32'(6 - rq[0].size()), 32'd5);
        #2;
        chk("cred_zero_again_ready", 32'(req_ready), 32'h0);
        credit_return = 1'b1;
        tick();
        drain(20, "cred_exhaust");

        // Return and accept in the same cycle at count 2 leave two credits.
        do_reset();
        auto_cr = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) push_flit(0, W'(8'h70 + k), 1'b1);
        predict(); drive_reqs();
        tick(); tick();
        chk("cred_two_spent", 32'(8 - rq[0].size()), 32'd2);
        credit_return = 1'b1;
        tick();
        chk("cred_same_cycle_accept", 32'(8 - rq[0].size()), 32'd3);
        repeat (6) tick();
        chk("cred_same_cycle_net", 32'(8 - rq[0].size()), 32'd5);

        // Return at full count is dropped and flagged sticky.
        do_reset();
        auto_cr = 1'b0; out_ready = 1'b1;
        #2;
        chk("cred_err_clear", 32'(credit_err), 32'h0);
        credit_return = 1'b1;
        tick();
        #2;
        chk("cred_err_set", 32'(credit_err), 32'h1);
        repeat (3) tick();
        chk("cred_err_sticky", 32'(credit_err), 32'h1);
        for (int k = 0; k < 6; k++) push_flit(1, W'(8'h90 + k), 1'b1);
        predict(); drive_reqs();
        repeat (8) tick();
        chk("cred_overflow_ignored", 32'(6 - rq[1].size()), 32'd4);
        chk("cred_err_persists", 32'(credit_err), 32'h1);

        // Reset in the middle of a packet locked on requester 2.
        do_reset();
        auto_cr = 1'b1; auto_rdy = 1'b0; out_ready = 1'b1;
        load_pkt(2, 4); predict(); drive_reqs();
        tick(); tick();
        #2;
        chk("lock_grant_id", 32'(grant_id), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid",  32'(out_valid), 32'h0);
        chk("midrst_out_data",   32'(out_data), 32'h0);
        chk("midrst_out_tail",   32'(out_tail), 32'h0);
        chk("midrst_grant_id",   32'(grant_id), 32'h0);
        chk("midrst_req_ready",  32'(req_ready), 32'h0);
        chk("midrst_credit_err", 32'(credit_err), 32'h0);
        for (int k = 0; k < N; k++) rq[k].delete();
        exp_q.delete();
        ds_occ = 0; mdl_ptr = 0; credit_return = 1'b0;
        drive_reqs();
        tick();
        rst_n = 1'b1;
        load_pkt(0, 1); load_pkt(1, 1); load_pkt(2, 2);
        predict(); drive_reqs();
        #2;
        chk("post_rst_ready", 32'(req_ready), 32'b001);
        drain(100, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
